// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS datapath and its controller: opcodes,
// FSM state codes, ALU/mux select values and the per-state control word.
package mips_mc_control_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_J     = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_EXEC_I   = 4'd5,
        ST_WB_I     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_HALT     = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore part of the control word; the FETCH pc/ir write pulse is added by the FSM.
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_BRANCH;
                c.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_WB_I: c.reg_write = 1'b1;
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath bundle: datapath status in, enables and mux selects out.
interface mips_mc_control_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source
    );
endinterface

// File: rtl/mips_wait_timer.sv
// Counts consecutive enabled cycles; reached is combinational and fires on the
// WAIT_MAX-th enabled cycle. clear has priority and restarts the count.
module mips_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic enable,
    input  logic clear,
    output logic reached
);
    localparam int W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [W-1:0] LAST = W'(WAIT_MAX - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign reached = enable && (cnt == LAST);
endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: Moore-decoded datapath controls, one state per cycle;
// memory states stall on mem_ready and abort to IDLE after WAIT_MAX stalled cycles.
module mips_mc_control
    import mips_mc_control_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                run,
    mips_mc_control_if.master   dp,
    output logic [3:0]          state,
    output logic                halted,
    output logic                illegal_op,
    output logic                mem_timeout
);
    state_t cur, nxt;
    ctrl_t  c;
    logic   run_q;
    logic   fetch_done;
    logic   timer_en, timer_clr, timer_hit;
    logic   zero_unused;

    // zero only matters to the datapath's pc_write_cond gating.
    assign zero_unused = dp.zero;

    always_ff @(posedge clk) begin
        if (!clear) begin
            cur         <= ST_IDLE;
            run_q       <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            cur   <= nxt;
            run_q <= run;
            if (timer_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign timer_en  = (cur inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) && !dp.mem_ready;
    assign timer_clr = !clear || dp.mem_ready || (nxt != cur);

    mips_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .enable  (timer_en),
        .clear   (timer_clr),
        .reached (timer_hit)
    );

    always_comb begin
        nxt        = cur;
        illegal_op = 1'b0;
        case (cur)
            ST_IDLE:  if (run) nxt = ST_FETCH;
            ST_FETCH: begin
                if (dp.mem_ready)   nxt = ST_DECODE;
                else if (timer_hit) nxt = ST_IDLE;
            end
            ST_DECODE: begin
                case (dp.opcode)
                    OP_RTYPE:     nxt = ST_EXEC_R;
                    OP_ADDI:      nxt = ST_EXEC_I;
                    OP_LW, OP_SW: nxt = ST_MEM_ADDR;
                    OP_BEQ:       nxt = ST_BRANCH;
                    OP_J:         nxt = ST_JUMP;
                    OP_HALT:      nxt = ST_HALT;
                    default: begin
                        nxt        = ST_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R:   nxt = ST_WB_R;
            ST_WB_R:     nxt = ST_FETCH;
            ST_EXEC_I:   nxt = ST_WB_I;
            ST_WB_I:     nxt = ST_FETCH;
            ST_MEM_ADDR: nxt = (dp.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (dp.mem_ready)   nxt = ST_MEM_WB;
                else if (timer_hit) nxt = ST_IDLE;
            end
            ST_MEM_WB:   nxt = ST_FETCH;
            ST_MEM_WR: begin
                if (dp.mem_ready)   nxt = ST_FETCH;
                else if (timer_hit) nxt = ST_IDLE;
            end
            ST_BRANCH:   nxt = ST_FETCH;
            ST_JUMP:     nxt = ST_FETCH;
            // Only a fresh rising edge of run restarts; a run held high stays halted.
            ST_HALT:     if (run && !run_q) nxt = ST_FETCH;
            default:     nxt = ST_IDLE;
        endcase
    end

    assign c          = ctrl_of(cur);
    assign fetch_done = (cur == ST_FETCH) && dp.mem_ready;

    assign dp.pc_write      = c.pc_write | fetch_done;
    assign dp.ir_write      = c.ir_write | fetch_done;
    assign dp.pc_write_cond = c.pc_write_cond;
    assign dp.mem_read      = c.mem_read;
    assign dp.mem_write     = c.mem_write;
    assign dp.iord          = c.iord;
    assign dp.reg_write     = c.reg_write;
    assign dp.reg_dst       = c.reg_dst;
    assign dp.mem_to_reg    = c.mem_to_reg;
    assign dp.alu_src_a     = c.alu_src_a;
    assign dp.alu_src_b     = c.alu_src_b;
    assign dp.alu_op        = c.alu_op;
    assign dp.pc_source     = c.pc_source;

    assign state  = cur;
    assign halted = (cur == ST_HALT);
endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum cycles spent waiting on mem_ready in any memory state before a timeout.
REQ-002 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 Port clear, input, 1: reset, synchronous, active-low.
REQ-004 Port run, input, 1: leaves IDLE/HALT when high.
REQ-005 Port opcode, input, 4: IR[15:12] from datapath instruction register.
REQ-006 Port zero, input, 1: ALU zero flag.
REQ-007 Port mem_ready, input, 1: memory completes current access this cycle.
REQ-008 Ports pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a: outputs, 1 each: datapath enables/selects.
REQ-009 Ports alu_src_b, alu_op, pc_source: outputs, 2 each: datapath mux selects and ALU mode.
REQ-010 Port state, output, 4: current state encoding, for debug.
REQ-011 Ports halted, illegal_op, mem_timeout: outputs, 1 each: status flags.

Function
REQ-012 The opcode map SHALL be: 0000 R-type, 0001 ADDI, 0010 LW, 0011 SW, 0100 BEQ, 0101 J, 1111 HALT; all other values are illegal.
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
REQ-014 IDLE -> FETCH when run=1; otherwise stay. All control outputs SHALL be 0 in IDLE.
REQ-015 FETCH SHALL assert mem_read, ir_write, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; pc_write and ir_write SHALL pulse for exactly the one cycle in which mem_ready=1, then -> DECODE; hold FETCH while mem_ready=0.
REQ-016 DECODE SHALL assert alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute), then dispatch: R-type->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, BEQ->BRANCH, J->JUMP, HALT->HALT, illegal->FETCH with illegal_op=1 for that one cycle.
REQ-017 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R; WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-018 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> WB_I; WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD (LW) or MEM_WR (SW).
REQ-020 MEM_RD: mem_read=1, iord=1; on mem_ready -> MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-021 MEM_WR: mem_write=1, iord=1; on mem_ready -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH; the PC update SHALL occur only when zero=1 (datapath gates with pc_write_cond).
REQ-023 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-024 HALT: halted=1, all enables 0; stay until run rises from 0 to 1 (edge-detected), then -> FETCH.
REQ-025 A wait counter SHALL count consecutive cycles with mem_ready=0 in FETCH, MEM_RD or MEM_WR; on reaching WAIT_MAX the FSM SHALL -> IDLE with mem_timeout=1 sticky until reset; no write enable is asserted in that cycle.
REQ-026 The wait counter SHALL clear on every state change and on mem_ready=1.
REQ-027 Write enables (pc_write, ir_write, reg_write, mem_write) SHALL be high for at most one cycle per instruction, except mem_write, which holds until mem_ready.
REQ-028 Outputs SHALL be Moore-decoded from state, except the FETCH pc_write/ir_write gating on mem_ready.

Reset
REQ-029 While clear=0 at a rising clk edge: state<=IDLE, wait counter<=0, halted/illegal_op/mem_timeout<=0, all control outputs 0, regardless of any in-flight access.
REQ-030 Reset asserted mid-MEM_WR SHALL deassert mem_write on the next edge.

Structure
REQ-031 Opcode constants, state encodings, and alu_op/alu_src_b/pc_source encodings SHALL reside in a shared package used by the datapath and this block.
REQ-032 The wait counter SHALL be a sub-module mips_wait_timer (enable, clear, count-reached output).

Verification
REQ-033 ADD (0x0xxx), mem_ready=1 always -> FETCH,DECODE,EXEC_R,WB_R; reg_write=1 only in cycle 4; 4 cycles total.
REQ-034 LW with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, reg_write with mem_to_reg=1 exactly once; 8 cycles total.
REQ-035 BEQ with zero=0 then zero=1 -> pc_write_cond=1, pc_source=01 in BRANCH both times; 3 cycles each.
REQ-036 Opcode 0x7 -> illegal_op pulse 1 cycle in DECODE, next state FETCH, no write enables.
REQ-037 mem_ready held 0 in FETCH, WAIT_MAX=15 -> IDLE after 15 cycles, mem_timeout=1 until clear=0.
REQ-038 HALT then run toggled 0->1 -> halted=1 until edge, then FETCH; clear=0 during MEM_WR -> IDLE and mem_write=0 next edge.
